// File: rtl/muldiv_sequencer_if.sv
// Command/result bundle between the pipeline and the HI/LO mult/div sequencer.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [11:0]     ctrl;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  // Pipeline side: issues commands, watches busy/done, reads HI/LO.
  modport master (
    output start, ctrl, src1, src2,
    input  busy, done, hi, lo
  );

  // Sequencer side.
  modport slave (
    input  start, ctrl, src1, src2,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: radix-2 shift-add multiply and restoring
// divide, one iteration per cycle, followed by a single sign-fix cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic                clk,
  input  logic                rst,
  muldiv_sequencer_if.slave   bus
);

  localparam int CW = $clog2(ITER);

  localparam logic [11:0] C_MULT  = 12'b000000_011000;
  localparam logic [11:0] C_MULTU = 12'b000000_011001;
  localparam logic [11:0] C_DIV   = 12'b000000_011010;
  localparam logic [11:0] C_DIVU  = 12'b000000_011011;
  localparam logic [11:0] C_MTHI  = 12'b000000_010001;
  localparam logic [11:0] C_MTLO  = 12'b000000_010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Multiply: {upper partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  // Multiplicand or divisor magnitude.
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;   // product / quotient negative
  logic              neg_rem_q, neg_rem_d;   // remainder takes dividend sign
  logic              dz_q, dz_d;             // divide by zero
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;

  // Datapath temporaries
  logic              is_muldiv, is_signed, is_div_cmd;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     shifted, trial, psum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  // Command decode and operand magnitudes for the accept cycle
  always_comb begin
    is_muldiv  = (bus.ctrl == C_MULT) || (bus.ctrl == C_MULTU) ||
                 (bus.ctrl == C_DIV)  || (bus.ctrl == C_DIVU);
    is_signed  = (bus.ctrl == C_MULT) || (bus.ctrl == C_DIV);
    is_div_cmd = (bus.ctrl == C_DIV)  || (bus.ctrl == C_DIVU);
    neg_a      = is_signed & bus.src1[XLEN-1];
    neg_b      = is_signed & bus.src2[XLEN-1];
    // 0x80000000 negates to itself, which is already the correct magnitude.
    mag_a      = neg_a ? (~bus.src1 + 1'b1) : bus.src1;
    mag_b      = neg_b ? (~bus.src2 + 1'b1) : bus.src2;
  end

  // Next-state, iteration datapath and HI/LO update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    shifted   = '0;
    trial     = '0;
    psum      = '0;
    prod      = '0;
    quo       = '0;
    rem       = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_muldiv) begin
            state_d   = CALC;
            cnt_d     = '0;
            is_div_d  = is_div_cmd;
            neg_res_d = neg_a ^ neg_b;
            neg_rem_d = neg_a;
            dz_d      = is_div_cmd && (bus.src2 == '0);
            if (is_div_cmd) begin
              acc_d = {{XLEN{1'b0}}, mag_a};
              opb_d = mag_b;
            end else begin
              acc_d = {{XLEN{1'b0}}, mag_b};
              opb_d = mag_a;
            end
          end else if (bus.ctrl == C_MTHI) begin
            hi_d = bus.src1;
          end else if (bus.ctrl == C_MTLO) begin
            lo_d = bus.src1;
          end
        end
      end

      CALC: begin
        if (is_div_q) begin
          // Remainder stays below the divisor, so 32 bits plus the bit
          // shifted in from the dividend cover the trial subtraction.
          shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
          trial   = shifted - {1'b0, opb_q};
          if (!trial[XLEN])
            acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else
            acc_d = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          psum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
          acc_d = {psum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1))
          state_d = FIX;
      end

      FIX: begin
        if (is_div_q) begin
          quo  = acc_q[XLEN-1:0];
          rem  = acc_q[2*XLEN-1:XLEN];
          // Divide by zero: quotient magnitude is all ones and the
          // remainder rebuilds the original dividend; force lo to all ones.
          lo_d = dz_q ? {XLEN{1'b1}} : (neg_res_q ? (~quo + 1'b1) : quo);
          hi_d = neg_rem_q ? (~rem + 1'b1) : rem;
        end else begin
          prod = neg_res_q ? (~acc_q + 1'b1) : acc_q;
          hi_d = prod[2*XLEN-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for the HI/LO mult/div sequencer.
module tb_muldiv_sequencer;

  localparam logic [11:0] C_MULT  = 12'b000000_011000;
  localparam logic [11:0] C_MULTU = 12'b000000_011001;
  localparam logic [11:0] C_DIV   = 12'b000000_011010;
  localparam logic [11:0] C_DIVU  = 12'b000000_011011;
  localparam logic [11:0] C_MTHI  = 12'b000000_010001;
  localparam logic [11:0] C_MTLO  = 12'b000000_010011;
  localparam logic [11:0] C_ADD   = 12'b000000_100000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer_if #(.XLEN(32)) mif ();

  muldiv_sequencer #(.XLEN(32), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [11:0] ctrl;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    int          inj;      // busy cycle on which to fire a stray start, 0 = none
    logic [11:0] ictrl;
    logic [31:0] ia;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue at the current negedge; return at the negedge of the done cycle.
  task automatic run_op(input vec_t v);
    int n;
    mif.start = 1'b1;
    mif.ctrl  = v.ctrl;
    mif.src1  = v.a;
    mif.src2  = v.b;
    @(negedge clk);
    mif.start = 1'b0;
    mif.ctrl  = C_ADD;
    mif.src1  = 32'h5A5A5A5A;
    mif.src2  = 32'hA5A5A5A5;
    n = 0;
    while (mif.busy && n < 100) begin
      n++;
      if (n == v.inj) begin
        mif.start = 1'b1;
        mif.ctrl  = v.ictrl;
        mif.src1  = v.ia;
        mif.src2  = 32'd1;
      end
      @(negedge clk);
      mif.start = 1'b0;
    end
    chk({v.name, " busy_cycles"}, 32'(n), 32'd33);
    chk({v.name, " done"}, {31'd0, mif.done}, 32'd1);
    chk({v.name, " hi"}, mif.hi, v.hi);
    chk({v.name, " lo"}, mif.lo, v.lo);
  endtask

  initial begin
    tbl[0] = '{"mult_neg3x7",   C_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0,  C_ADD,  32'd0};
    tbl[1] = '{"multu_max",     C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 10, C_DIVU, 32'd3};
    tbl[2] = '{"div_neg7by2",   C_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0,  C_ADD,  32'd0};
    tbl[3] = '{"divu_100by7",   C_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       0,  C_ADD,  32'd0};
    tbl[4] = '{"div_5by0",      C_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 0,  C_ADD,  32'd0};
    tbl[5] = '{"div_ovf",       C_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 0,  C_ADD,  32'd0};
    tbl[6] = '{"div_neg7by0",   C_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 0,  C_ADD,  32'd0};
    tbl[7] = '{"mult_minsq",    C_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0,  C_ADD,  32'd0};
    tbl[8] = '{"multu_min_x2",  C_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 5,  C_MTLO, 32'hDEADBEEF};

    mif.start = 1'b0;
    mif.ctrl  = C_ADD;
    mif.src1  = '0;
    mif.src2  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", {31'd0, mif.busy}, 32'd0);
    chk("reset done", {31'd0, mif.done}, 32'd0);
    chk("reset hi", mif.hi, 32'd0);
    chk("reset lo", mif.lo, 32'd0);

    // Table-driven mult/div vectors
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i]);
      @(negedge clk);
      chk({tbl[i].name, " done_one_cycle"}, {31'd0, mif.done}, 32'd0);
    end

    // Back-to-back: new start in the done cycle is accepted
    begin
      vec_t v1, v2;
      v1 = '{"b2b_first",  C_MULT, 32'd6,   32'd7, 32'd0, 32'd42, 0, C_ADD, 32'd0};
      v2 = '{"b2b_second", C_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, C_ADD, 32'd0};
      run_op(v1);
      run_op(v2);
      @(negedge clk);
    end

    // Unknown ctrl ignored
    mif.start = 1'b1; mif.ctrl = C_ADD; mif.src1 = 32'h11111111; mif.src2 = 32'd3;
    @(negedge clk);
    mif.start = 1'b0;
    chk("ignored busy", {31'd0, mif.busy}, 32'd0);
    chk("ignored lo", mif.lo, 32'd14);

    // MTHI then MTLO, each on its own edge
    mif.start = 1'b1; mif.ctrl = C_MTHI; mif.src1 = 32'h12345678;
    @(negedge clk);
    chk("mthi hi", mif.hi, 32'h12345678);
    chk("mthi lo_held", mif.lo, 32'd14);
    chk("mthi busy", {31'd0, mif.busy}, 32'd0);
    mif.ctrl = C_MTLO; mif.src1 = 32'hCAFEBABE;
    @(negedge clk);
    mif.start = 1'b0;
    chk("mtlo lo", mif.lo, 32'hCAFEBABE);
    chk("mtlo hi_held", mif.hi, 32'h12345678);
    chk("mtlo busy", {31'd0, mif.busy}, 32'd0);
    chk("mtlo done", {31'd0, mif.done}, 32'd0);

    // MULT 6x7 with a stray MTLO while busy, then reset mid-calc
    mif.start = 1'b1; mif.ctrl = C_MULT; mif.src1 = 32'd6; mif.src2 = 32'd7;
    @(negedge clk);
    mif.start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        mif.start = 1'b1; mif.ctrl = C_MTLO; mif.src1 = 32'hDEADBEEF;
      end
      if (k == 16) rst = 1'b1;
      @(negedge clk);
      mif.start = 1'b0;
      if (k == 10) begin
        chk("abort busy_mid", {31'd0, mif.busy}, 32'd1);
        chk("abort lo_held", mif.lo, 32'hCAFEBABE);
        chk("abort hi_held", mif.hi, 32'h12345678);
      end
    end
    rst = 1'b0;
    chk("abort busy", {31'd0, mif.busy}, 32'd0);
    chk("abort done", {31'd0, mif.done}, 32'd0);
    chk("abort hi", mif.hi, 32'd0);
    chk("abort lo", mif.lo, 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (mif.done || mif.busy) seen++;
      end
      chk("abort no_done", 32'(seen), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the HI/LO multiply/divide path of the MIPS core, beside the combinational ALU.
- Accepts a MULT/MULTU/DIV/DIVU/MTHI/MTLO command using the same 12-bit ctrl encoding as the ALU ({opcode[5:0], funct[5:0]}).
- Sequences a radix-2 shift-add multiply or restoring divide over 32 iterations, then a sign-fix step.
- Holds busy so the pipeline stalls MFHI/MFLO until HI/LO are valid.

Parameters:
- XLEN, 32, operand and HI/LO width. Only 32 is supported.
- ITER, 32, iteration count. Must equal XLEN.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  command valid, sampled on each rising clk edge
- ctrl  in  12  command code, {opcode, funct}
- src1  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data
- src2  in  32  rt operand: multiplier or divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: HI/LO just updated by a mult/div
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Decoded ctrl values:
  - MULT = 000000_011000
  - MULTU = 000000_011001
  - DIV = 000000_011010
  - DIVU = 000000_011011
  - MTHI = 000000_010001
  - MTLO = 000000_010011
  - Any other value with start=1 is ignored: no state change, busy stays 0.
- Reset (rst=1 at an edge) has priority over everything, including mid-operation:
  - state=IDLE, busy=0, done=0, hi=0, lo=0.
  - Iteration counter and internal accumulators are cleared.
  - Any in-flight operation is discarded.
- States: IDLE, CALC, FIX.
- IDLE:
  - start with a mult/div code: latch the operand magnitudes (absolute values for the signed ops, raw for the unsigned ops), latch the result sign flags, clear the counter, go to CALC. busy=1 from the next cycle.
  - start with MTHI: hi<=src1 on that edge. Stay IDLE; busy and done stay 0.
  - start with MTLO: lo<=src1 on that edge. Stay IDLE; busy and done stay 0.
- CALC: one iteration per cycle, counter 0..31.
  - Multiply: 64-bit product accumulator, shift-add on the multiplier LSB.
  - Divide: restoring divide. Shift the remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - After the 32nd iteration (counter==31), go to FIX.
- FIX (one cycle), then return to IDLE:
  - Apply sign correction. Signed multiply: negate the 64-bit product if the operand signs differ. Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo on this cycle's edge: mult gives {hi,lo}=product; div gives lo=quotient, hi=remainder.
  - In the following cycle: done=1 and busy=0.
- Latency: start accepted at edge E; busy=1 for the cycles after edges E..E+32 (33 cycles). hi/lo update and done rise at edge E+33. done lasts exactly one cycle.
- hi/lo hold their previous values throughout CALC; partial results are never visible.
- start while busy=1 is ignored (including MTHI/MTLO). The sequencer does not queue commands.
- start in the done cycle is accepted normally; the sequencer is already in IDLE.
- Divide by zero (src2==0) runs the full latency. Result: lo=32'hFFFFFFFF, hi=dividend (src1 as supplied, sign preserved). No trap.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Unsigned/signed width: all internal arithmetic is 33 bits for the divide and 64 bits for the multiply. Magnitude of 0x80000000 is 0x80000000 unsigned.
- ctrl, src1 and src2 are don't-care except in the cycle start is accepted.

Test Plan:
- Reset, then MULT src1=-3 (0xFFFFFFFD), src2=7 -> busy high 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB with a single-cycle done.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. A second start issued at cycle 10 is ignored and does not alter the result.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIV 5/0 -> after 33 busy cycles, lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678, then MTLO 0xCAFEBABE -> each takes effect on its own edge; busy and done stay 0. MTLO issued while busy is ignored.
- Start MULT 6×7, assert rst at iteration 15 -> the next cycle has busy=0, done=0, hi=lo=0. done never pulses for the aborted op.
